rtc_bus_master: RTL
===================

Name: rtc_bus_master

Overview:
Parametrised master for the RTC chip's multiplexed address/data bus (active-low CS, AD, RD, WR).
It accepts one read or write request at a time over a valid/ready handshake and runs two phases:
- an address phase, then a data phase;
- each sub-phase lasts a programmable number of cycles.
Read data is captured and returned with a one-cycle response strobe. The block sits between the RTC register-access sequencer and the top-level bus pins.

Parameters:
DATA_W, 8, width of bus data and request address/data
T_AS, 1, cycles of address setup (AD low, CS/WR high) before the address strobe
T_AW, 6, cycles of address strobe (CS and WR low)
T_AH, 2, cycles of address hold (CS/WR high, AD still low)
T_GAP, 10, cycles of idle gap between the phases (all strobes high)
T_DW, 6, cycles of data strobe (CS low plus WR or RD low)
T_DH, 2, cycles of data hold (all strobes high) before completion
CNT_W, 5, phase counter width; must hold max(T_*)-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block idle and able to accept
req_write  in  1  1 = write, 0 = read
req_addr  in  DATA_W  RTC register address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  last captured read data
busy  out  1  transaction in progress
cs_n  out  1  chip select, active low
ad_n  out  1  0 = address phase on bus
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
bus_dout  out  DATA_W  value driven onto the bus
bus_oe  out  1  1 = drive bus_dout (pad tristate control)
bus_din  in  DATA_W  bus value sampled during reads

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All outputs are registered except req_ready, which equals (state==IDLE).
- Reset values: cs_n=ad_n=rd_n=wr_n=1, bus_oe=0, bus_dout=0, rsp_valid=0, rsp_rdata=0, busy=0; state is IDLE.
- Reset asserted mid-transaction: at the next edge the block enters IDLE with the reset values above; no rsp_valid is issued.
- Request acceptance: a request is accepted on the edge where req_valid && req_ready. At that edge req_write, req_addr and req_wdata are latched, and the state becomes ADDR_SETUP.
- Request inputs outside acceptance are ignored; there is no queueing.
- Phase order: ADDR_SETUP -> ADDR_STROBE -> ADDR_HOLD -> GAP -> DATA_STROBE -> DATA_HOLD -> DONE -> IDLE.
  - Each phase lasts exactly its T_* cycles, counted by a down-counter loaded with T_*-1 on entry.
  - DONE lasts 1 cycle.
- Outputs per state:
  - IDLE: all strobes 1, oe=0, busy=0.
  - ADDR_SETUP: ad_n=0, bus_dout=addr, oe=1.
  - ADDR_STROBE: ad_n=0, cs_n=0, wr_n=0, oe=1.
  - ADDR_HOLD: ad_n=0, cs_n=wr_n=1, oe=1.
  - GAP: all strobes 1.
    - Write: oe=1 with bus_dout=wdata, so the data is set up early.
    - Read: oe=0.
  - DATA_STROBE: cs_n=0.
    - Write: wr_n=0, oe=1, bus_dout=wdata.
    - Read: rd_n=0, oe=0.
  - DATA_HOLD: all strobes 1.
    - Write: oe stays 1.
    - Read: oe=0.
  - DONE: all strobes 1, oe=0, rsp_valid=1.
- busy is 1 in every state other than IDLE.
- rd_n and wr_n are never both 0. bus_oe is never 1 while rd_n=0.
- Read capture: rsp_rdata <= bus_din on the final edge of DATA_STROBE, while rd_n is still 0. rsp_rdata holds until the next read capture; writes leave it unchanged.
- Latency with defaults:
  - Phase sum S = 27 cycles.
  - rsp_valid is high in cycle S+1 after the acceptance edge.
  - req_ready returns to 1 in the following cycle, so the minimum request spacing is S+2 = 29 cycles.
- A T_* value of 0 is illegal; it is flagged by a simulation-only check at elaboration.

Optional Feature:
Macro: RTC_BUS_SKIP_ADDR_EN.
- With the macro defined:
  - A last_addr register and a last_valid flag are kept. Both are cleared by reset.
  - On each completed transaction, last_addr is set to the latched address and last_valid is set to 1.
  - If an accepted request has last_valid=1 and req_addr==last_addr, the block skips ADDR_SETUP, ADDR_STROBE and ADDR_HOLD and goes directly to GAP.
  - Latency is then reduced by T_AS+T_AW+T_AH, i.e. by 9 cycles with defaults.
- Without the macro: every transaction runs the full address phase, and last_addr/last_valid do not exist.

Test Plan:
1. Reset held 3 cycles, then released -> all strobes 1, bus_oe=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
2. Write: addr=0x0A, wdata=0x5C -> in the address phase, ad_n=0 and bus_dout=0x0A during a 6-cycle cs_n/wr_n low pulse. In the data phase, wr_n low 6 cycles with bus_dout=0x5C and bus_oe=1. rsp_valid goes high exactly 28 cycles after acceptance; rd_n stays 1 throughout.
3. Read: addr=0x04, bus model drives 0x37 only while rd_n=0 -> rd_n low for 6 cycles with bus_oe=0, rsp_rdata=0x37 with rsp_valid, and wr_n never low in the data phase.
4. req_valid held high continuously for two requests -> second acceptance occurs 29 cycles after the first; req_ready=0 throughout the first transaction, and inputs changed mid-transaction have no effect.
5. Reset asserted during DATA_STROBE of a write -> next cycle all strobes 1, bus_oe=0, no rsp_valid; a new request afterwards completes normally.
6. RTC_BUS_SKIP_ADDR_EN defined, two reads of 0x0C -> second read has no ad_n=0 cycles and completes in 19 cycles. A following read of 0x0D runs the full 28-cycle sequence.

Source files
------------

// File: rtl/rtc_bus_master_if.sv
// Request/response handshake and multiplexed RTC bus pins for rtc_bus_master.
// master: the bus-master block; slave: the requesting sequencer plus the pad/bus side.
interface rtc_bus_master_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;
   logic              cs_n;
   logic              ad_n;
   logic              rd_n;
   logic              wr_n;
   logic [DATA_W-1:0] bus_dout;
   logic              bus_oe;
   logic [DATA_W-1:0] bus_din;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, bus_din,
      output req_ready, rsp_valid, rsp_rdata, busy,
      output cs_n, ad_n, rd_n, wr_n, bus_dout, bus_oe
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, bus_din,
      input  req_ready, rsp_valid, rsp_rdata, busy,
      input  cs_n, ad_n, rd_n, wr_n, bus_dout, bus_oe
   );
endinterface

// File: rtl/rtc_bus_master.sv
// Master for the RTC multiplexed address/data bus: address phase, gap, data phase, done.
// Optional: define RTC_BUS_SKIP_ADDR_EN to skip the address phase on a repeated address.
module rtc_bus_master #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned T_AS   = 1,
   parameter int unsigned T_AW   = 6,
   parameter int unsigned T_AH   = 2,
   parameter int unsigned T_GAP  = 10,
   parameter int unsigned T_DW   = 6,
   parameter int unsigned T_DH   = 2,
   parameter int unsigned CNT_W  = 5
) (
   input logic              clk,
   input logic              reset,
   rtc_bus_master_if.master bus
);
   localparam logic [2:0] StIdle       = 3'd0;
   localparam logic [2:0] StAddrSetup  = 3'd1;
   localparam logic [2:0] StAddrStrobe = 3'd2;
   localparam logic [2:0] StAddrHold   = 3'd3;
   localparam logic [2:0] StGap        = 3'd4;
   localparam logic [2:0] StDataStrobe = 3'd5;
   localparam logic [2:0] StDataHold   = 3'd6;
   localparam logic [2:0] StDone       = 3'd7;

   localparam logic [CNT_W-1:0] LdAs  = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LdAw  = CNT_W'(T_AW - 1);
   localparam logic [CNT_W-1:0] LdAh  = CNT_W'(T_AH - 1);
   localparam logic [CNT_W-1:0] LdGap = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] LdDw  = CNT_W'(T_DW - 1);
   localparam logic [CNT_W-1:0] LdDh  = CNT_W'(T_DH - 1);

   if (T_AS == 0 || T_AW == 0 || T_AH == 0 || T_GAP == 0 || T_DW == 0 || T_DH == 0)
   begin : g_bad_timing
      $error("rtc_bus_master: all T_* parameters must be non-zero");
   end

   if (T_AS > 2**CNT_W || T_AW > 2**CNT_W || T_AH > 2**CNT_W || T_GAP > 2**CNT_W ||
       T_DW > 2**CNT_W || T_DH > 2**CNT_W) begin : g_bad_cnt_w
      $error("rtc_bus_master: CNT_W too narrow for the T_* parameters");
   end

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              cs_n_q, cs_n_d, ad_n_q, ad_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
   logic              oe_q, oe_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              busy_q, rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              skip_addr;

`ifdef RTC_BUS_SKIP_ADDR_EN
   logic [DATA_W-1:0] last_addr_q;
   logic              last_valid_q;

   assign skip_addr = last_valid_q && (bus.req_addr == last_addr_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_addr_q  <= '0;
         last_valid_q <= 1'b0;
      end else if (state_q == StDone) begin
         last_addr_q  <= addr_q;
         last_valid_q <= 1'b1;
      end
   end
`else
   assign skip_addr = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (state_q == StIdle) begin
         if (bus.req_valid) begin
            write_d = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = skip_addr ? StGap : StAddrSetup;
            cnt_d   = skip_addr ? LdGap : LdAs;
         end
      end else if (state_q == StDone) begin
         state_d = StIdle;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         case (state_q)
            StAddrSetup:  begin state_d = StAddrStrobe; cnt_d = LdAw;  end
            StAddrStrobe: begin state_d = StAddrHold;   cnt_d = LdAh;  end
            StAddrHold:   begin state_d = StGap;        cnt_d = LdGap; end
            StGap:        begin state_d = StDataStrobe; cnt_d = LdDw;  end
            StDataStrobe: begin state_d = StDataHold;   cnt_d = LdDh;  end
            StDataHold:   state_d = StDone;
            default:      state_d = StIdle;
         endcase
      end
   end

   // Pin values are decoded from the next state so the registered pins line up with the state.
   always_comb begin
      cs_n_d = 1'b1;
      ad_n_d = 1'b1;
      rd_n_d = 1'b1;
      wr_n_d = 1'b1;
      oe_d   = 1'b0;
      dout_d = '0;
      case (state_d)
         StAddrSetup, StAddrHold: begin
            ad_n_d = 1'b0;
            oe_d   = 1'b1;
            dout_d = addr_d;
         end
         StAddrStrobe: begin
            ad_n_d = 1'b0;
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            dout_d = addr_d;
         end
         StGap, StDataHold: begin
            oe_d   = write_d;
            dout_d = write_d ? wdata_d : '0;
         end
         StDataStrobe: begin
            cs_n_d = 1'b0;
            wr_n_d = !write_d;
            rd_n_d = write_d;
            oe_d   = write_d;
            dout_d = write_d ? wdata_d : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cs_n_q      <= 1'b1;
         ad_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         oe_q        <= 1'b0;
         dout_q      <= '0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cs_n_q      <= cs_n_d;
         ad_n_q      <= ad_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         oe_q        <= oe_d;
         dout_q      <= dout_d;
         busy_q      <= (state_d != StIdle);
         rsp_valid_q <= (state_d == StDone);
         // Last read-strobe edge: rd_n is still low on the pins here.
         if (state_q == StDataStrobe && cnt_q == '0 && !write_q) begin
            rsp_rdata_q <= bus.bus_din;
         end
      end
   end

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.busy      = busy_q;
   assign bus.cs_n      = cs_n_q;
   assign bus.ad_n      = ad_n_q;
   assign bus.rd_n      = rd_n_q;
   assign bus.wr_n      = wr_n_q;
   assign bus.bus_dout  = dout_q;
   assign bus.bus_oe    = oe_q;
endmodule
